// File: rtl/axis_seg_pkg.sv
// Shared types and helpers for the AXI4-Stream frame segmenter.
// Holds the FSM state encoding and the byte-length arithmetic used
// to turn a descriptor length into a word count and a last-word keep mask.
package axis_seg_pkg;

  // Widest keep bus the helpers support (1024-bit data bus).
  localparam int MAX_KEEP_WIDTH = 128;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Number of bus words needed to carry len_bytes bytes (ceiling divide).
  function automatic int unsigned words_ceil(input int unsigned len_bytes,
                                             input int unsigned keep_width);
    return (len_bytes + keep_width - 1) / keep_width;
  endfunction

  // Keep mask for the final word of a frame: low (len mod width) bits set,
  // or a full word when the length is an exact multiple of the width.
  function automatic logic [MAX_KEEP_WIDTH-1:0] keep_mask(input int unsigned len_bytes,
                                                          input int unsigned keep_width);
    int unsigned rem;
    rem = len_bytes % keep_width;
    if (rem == 0) begin
      rem = keep_width;
    end
    // A shift of the full 128 bits wraps to zero, so the subtraction still
    // yields all ones for the widest supported bus.
    return (MAX_KEEP_WIDTH'(1) << rem) - MAX_KEEP_WIDTH'(1);
  endfunction

endpackage

// File: rtl/axis_frame_segmenter.sv
// AXI4-Stream frame segmenter: frames an unframed payload word stream using
// byte lengths from a descriptor port, generating tlast, last-word tkeep,
// tdest and tuser behind a single output register stage.
// Optional build macro AXIS_SEG_B2B_EN: accept the next descriptor on the
// final payload handshake of a frame so consecutive frames have no gap.
module axis_frame_segmenter
  import axis_seg_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 16,
  parameter int DEST_WIDTH = 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LEN_WIDTH-1:0]  desc_len,
  input  logic [DEST_WIDTH-1:0] desc_dest,
  input  logic [USER_WIDTH-1:0] desc_user,
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic                  status_busy,
  output logic                  status_frame_done,
  output logic                  status_bad_desc
);

  // Enough bits for the word count of a maximum-length frame.
  localparam int WR_WIDTH = LEN_WIDTH - $clog2(KEEP_WIDTH) + 1;

`ifdef AXIS_SEG_B2B_EN
  localparam bit B2B_EN = 1'b1;
`else
  localparam bit B2B_EN = 1'b0;
`endif

  state_t                  state_reg;
  logic [WR_WIDTH-1:0]     words_rem_reg;
  logic [KEEP_WIDTH-1:0]   last_keep_reg;
  logic [DEST_WIDTH-1:0]   dest_reg;
  logic [USER_WIDTH-1:0]   user_reg;

  logic [DATA_WIDTH-1:0]   m_tdata_reg;
  logic [KEEP_WIDTH-1:0]   m_tkeep_reg;
  logic                    m_tvalid_reg;
  logic                    m_tlast_reg;
  logic [DEST_WIDTH-1:0]   m_tdest_reg;
  logic [USER_WIDTH-1:0]   m_tuser_reg;
  logic                    frame_done_reg;
  logic                    bad_desc_reg;

  logic                    s_hs;
  logic                    m_hs;
  logic                    last_hs;
  logic                    desc_hs;
  logic                    desc_nonzero;
  logic [WR_WIDTH-1:0]     desc_words;
  logic [KEEP_WIDTH-1:0]   desc_keep;

  // Handshake and flow-control decode. The payload side only moves in
  // STREAM and only when the output register is empty or draining.
  assign m_hs          = m_tvalid_reg && m_axis_tready;
  assign s_axis_tready = !rst && (state_reg == STREAM) && (!m_tvalid_reg || m_axis_tready);
  assign s_hs          = s_axis_tvalid && s_axis_tready;
  assign last_hs       = s_hs && (words_rem_reg == WR_WIDTH'(1));
  assign desc_ready    = !rst && ((state_reg == IDLE) || (B2B_EN && last_hs));
  assign desc_hs       = desc_valid && desc_ready;
  assign desc_nonzero  = (desc_len != '0);
  assign desc_words    = WR_WIDTH'(words_ceil(32'(desc_len), KEEP_WIDTH));
  assign desc_keep     = KEEP_WIDTH'(keep_mask(32'(desc_len), KEEP_WIDTH));

  assign m_axis_tdata      = m_tdata_reg;
  assign m_axis_tkeep      = m_tkeep_reg;
  assign m_axis_tvalid     = m_tvalid_reg;
  assign m_axis_tlast      = m_tlast_reg;
  assign m_axis_tdest      = m_tdest_reg;
  assign m_axis_tuser      = m_tuser_reg;
  assign status_busy       = (state_reg == STREAM);
  assign status_frame_done = frame_done_reg;
  assign status_bad_desc   = bad_desc_reg;

  // FSM, word counter, output valid/last and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      words_rem_reg  <= '0;
      m_tvalid_reg   <= 1'b0;
      m_tlast_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      bad_desc_reg   <= 1'b0;
    end else begin
      frame_done_reg <= m_hs && m_tlast_reg;
      bad_desc_reg   <= desc_hs && !desc_nonzero;

      if (s_hs) begin
        m_tvalid_reg  <= 1'b1;
        m_tlast_reg   <= last_hs;
        words_rem_reg <= words_rem_reg - WR_WIDTH'(1);
      end else if (m_hs) begin
        m_tvalid_reg  <= 1'b0;
      end

      if ((state_reg == STREAM) && last_hs) begin
        state_reg <= IDLE;
      end

      // A descriptor can only be accepted in IDLE or on the final payload
      // handshake, so this load never collides with a live frame.
      if (desc_hs && desc_nonzero) begin
        state_reg     <= STREAM;
        words_rem_reg <= desc_words;
      end
    end
  end

  // Datapath registers; their contents are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (desc_hs && desc_nonzero) begin
      last_keep_reg <= desc_keep;
      dest_reg      <= desc_dest;
      user_reg      <= desc_user;
    end
    if (s_hs) begin
      m_tdata_reg <= s_axis_tdata;
      m_tkeep_reg <= last_hs ? last_keep_reg : '1;
      m_tdest_reg <= dest_reg;
      m_tuser_reg <= user_reg;
    end
  end

endmodule
